// File: rtl/data_mem_bus.sv
// Data RAM plus optional timer MMIO window for a single-cycle RV32 core.
// Define DM_TIMER_EN to build the COUNT/COMPARE/CTRL/STATUS timer.
module data_mem_bus #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    input  logic [3:0]  LOADSel,
    input  logic [1:0]  STORESel,
    output logic [31:0] readdata,
    output logic        err,
    output logic        irq
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic          r_err;
    logic          w_ld_b, w_ld_h, w_ld_sx, w_ld_chk;
    logic          w_st_b, w_st_h;
    logic          w_in_win, w_in_ram, w_in_tmr;
    logic          w_ld_mis, w_st_mis, w_ld_bad, w_st_bad;
    logic          w_ram_we, w_err_set;
    logic [31:0]   w_toff, w_word, w_shift, w_tmr_rd, w_wdat;
    logic [15:0]   w_half;
    logic [3:0]    w_be;
    logic [AW-1:0] w_widx;

    assign w_widx   = addr[AW+1:2];
    assign w_toff   = addr - MMIO_BASE;
    assign w_in_win = (w_toff < 32'd16);
    assign w_in_ram = (addr < RAM_BYTES) && !w_in_win;

    always_comb begin
        w_ld_b   = 1'b0;
        w_ld_h   = 1'b0;
        w_ld_sx  = 1'b0;
        w_ld_chk = 1'b1;
        unique case (LOADSel)
            4'd0: ;
            4'd1: begin w_ld_b = 1'b1; w_ld_sx = 1'b1; end
            4'd2: w_ld_b = 1'b1;
            4'd3: begin w_ld_h = 1'b1; w_ld_sx = 1'b1; end
            4'd4: w_ld_h = 1'b1;
            default: w_ld_chk = 1'b0;
        endcase
    end

    assign w_st_b = (STORESel == 2'd1);
    assign w_st_h = (STORESel == 2'd2);

    // Timer registers are word-only: any narrower access counts as misaligned.
    assign w_ld_mis = w_in_tmr ? (w_ld_b || w_ld_h || addr[1:0] != 2'd0)
                    : w_ld_h   ? addr[0]
                    : (!w_ld_b && addr[1:0] != 2'd0);
    assign w_st_mis = w_in_tmr ? (w_st_b || w_st_h || addr[1:0] != 2'd0)
                    : w_st_h   ? addr[0]
                    : (!w_st_b && addr[1:0] != 2'd0);

    assign w_ld_bad = w_ld_mis || !(w_in_ram || w_in_tmr);
    assign w_st_bad = w_st_mis || !(w_in_ram || w_in_tmr);

    assign w_word  = w_in_tmr ? w_tmr_rd : r_mem[w_widx];
    assign w_shift = w_word >> {addr[1:0], 3'b000};
    assign w_half  = addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        readdata = w_word;
        if (w_ld_bad)
            readdata = '0;
        else if (w_ld_b)
            readdata = {{24{w_ld_sx & w_shift[7]}}, w_shift[7:0]};
        else if (w_ld_h)
            readdata = {{16{w_ld_sx & w_half[15]}}, w_half};
    end

    always_comb begin
        w_be   = 4'hF;
        w_wdat = writedata;
        if (w_st_b) begin
            w_be   = 4'b0001 << addr[1:0];
            w_wdat = {4{writedata[7:0]}};
        end else if (w_st_h) begin
            w_be   = addr[1] ? 4'b1100 : 4'b0011;
            w_wdat = {2{writedata[15:0]}};
        end
    end

    assign w_ram_we = MemWrite && !rst && !w_st_bad && w_in_ram;

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            if (w_be[0]) r_mem[w_widx][7:0]   <= w_wdat[7:0];
            if (w_be[1]) r_mem[w_widx][15:8]  <= w_wdat[15:8];
            if (w_be[2]) r_mem[w_widx][23:16] <= w_wdat[23:16];
            if (w_be[3]) r_mem[w_widx][31:24] <= w_wdat[31:24];
        end
    end

    assign w_err_set = MemWrite ? w_st_bad : (w_ld_chk && w_ld_bad);

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_err_set)
            r_err <= 1'b1;
    end

    assign err = r_err;

`ifdef DM_TIMER_EN
    logic [31:0] r_count, r_cmp;
    logic [2:0]  r_ctrl;
    logic        r_match;
    logic        w_tmr_we, w_hit;

    assign w_in_tmr = w_in_win;
    assign w_tmr_we = MemWrite && !w_st_bad && w_in_tmr;
    assign w_hit    = r_ctrl[0] && (r_count == r_cmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_cmp   <= '0;
            r_ctrl  <= '0;
            r_match <= 1'b0;
        end else begin
            if (w_tmr_we && w_toff[3:2] == 2'd0)
                r_count <= writedata;
            else if (w_hit && r_ctrl[1])
                r_count <= '0;
            else if (r_ctrl[0])
                r_count <= r_count + 32'd1;
            if (w_tmr_we && w_toff[3:2] == 2'd1)
                r_cmp <= writedata;
            if (w_tmr_we && w_toff[3:2] == 2'd2)
                r_ctrl <= writedata[2:0];
            if (w_hit)
                r_match <= 1'b1;
            else if (w_tmr_we && w_toff[3:2] == 2'd3 && writedata[0])
                r_match <= 1'b0;
        end
    end

    always_comb begin
        unique case (w_toff[3:2])
            2'd0: w_tmr_rd = r_count;
            2'd1: w_tmr_rd = r_cmp;
            2'd2: w_tmr_rd = {29'd0, r_ctrl};
            default: w_tmr_rd = {31'd0, r_match};
        endcase
    end

    assign irq = r_match & r_ctrl[2];
`else
    assign w_in_tmr = 1'b0;
    assign w_tmr_rd = '0;
    assign irq      = 1'b0;
`endif

endmodule

// File: doc/data_mem_bus.md
DATA_MEM_BUS -- requirements
Module: data_mem_bus

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit data RAM words at byte address 0.
REQ-002 The block SHALL have parameter MMIO_BASE, default 32'h0000_7F00, giving the base byte address of the timer register window.
REQ-003 The block SHALL have the port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have the port MemWrite  input  1  store strobe from the CPU.
REQ-006 The block SHALL have the port addr  input  32  byte address, driven by the CPU ALU result.
REQ-007 The block SHALL have the port writedata  input  32  store data, with the byte or half taken from the low bits.
REQ-008 The block SHALL have the port LOADSel  input  4  load type: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; other values act as lw.
REQ-009 The block SHALL have the port STORESel  input  2  store type: 0 sw, 1 sb, 2 sh; 3 acts as sw.
REQ-010 The block SHALL have the port readdata  output  32  load result, extended, returned to the CPU.
REQ-011 The block SHALL have the port err  output  1  sticky access-error flag.
REQ-012 The block SHALL have the port irq  output  1  timer interrupt request.

Function
REQ-013 readdata SHALL be combinational from addr, LOADSel and current state, giving zero-cycle load latency for the single-cycle CPU.
REQ-014 Byte and half loads SHALL select the lane from addr[1:0] (little-endian); lb/lh sign-extend and lbu/lhu zero-extend to 32 bits.
REQ-015 When MemWrite=1, stores SHALL update only the addressed lanes at the clock edge: sb writes 1 byte, sh writes 2 bytes, sw writes 4 bytes.
REQ-016 An access SHALL be misaligned when lw/sw has addr[1:0]!=0, or lh/lhu/sh has addr[0]=1.
REQ-017 An access SHALL be out-of-range when addr >= DEPTH_WORDS*4 and addr is not in the timer window.
REQ-018 For a misaligned or out-of-range access, a load SHALL return 0.
REQ-019 For a misaligned or out-of-range access, a store SHALL change no state.
REQ-020 For a misaligned or out-of-range store, err SHALL be set at the next edge.
REQ-021 For a misaligned or out-of-range load, err SHALL be set at the next edge whenever the address is checked; a load is checked when MemWrite=0 and LOADSel is 0-4.
REQ-022 err SHALL remain set until rst.
REQ-023 Timer register COUNT (MMIO_BASE+0x0) SHALL be read/write.
REQ-024 Timer register COMPARE (MMIO_BASE+0x4) SHALL be read/write.
REQ-025 Timer register CTRL (MMIO_BASE+0x8) SHALL be read/write, with bit0 = enable, bit1 = auto-reload, bit2 = interrupt enable; the other bits read 0.
REQ-026 Timer register STATUS (MMIO_BASE+0xC) SHALL hold bit0 = match; writing 1 to bit0 clears it.
REQ-027 Timer registers SHALL accept lw/sw only; any other width SHALL be treated as misaligned.
REQ-028 COUNT SHALL increment by 1 per cycle while CTRL.enable=1, wrapping from 32'hFFFF_FFFF to 0.
REQ-029 When COUNT==COMPARE and enable=1, match SHALL be set at the next edge.
REQ-030 On that edge, COUNT SHALL load 0 if auto-reload=1; otherwise it SHALL increment.
REQ-031 irq SHALL equal STATUS.match AND CTRL.ie, with no extra register stage.
REQ-032 When a store to COUNT coincides with an increment, the store SHALL take priority.
REQ-033 When a write-1-clear of match coincides with a new match, set SHALL take priority.
REQ-034 A write to CTRL SHALL take effect from the following cycle.

Reset
REQ-035 When rst=1 at an edge, COUNT, COMPARE, CTRL, STATUS and err SHALL be cleared to 0.
REQ-036 While rst=1, MemWrite SHALL be ignored.
REQ-037 Data RAM contents SHALL NOT be reset.
REQ-038 readdata SHALL reflect state combinationally, so after reset timer reads SHALL return 0 and irq SHALL be 0.
REQ-039 A reset asserted mid-count SHALL discard the timer state the same cycle.

Configuration
REQ-040 With DM_TIMER_EN defined, the timer SHALL be compiled in as described above.
REQ-041 Without DM_TIMER_EN, the timer window SHALL be decoded as out-of-range.
REQ-042 Without DM_TIMER_EN, irq SHALL be tied to 0 and no timer flops SHALL exist.

Verification
REQ-043 The bench SHALL cover: sw 32'h8081_7F01 @0x10, then lb @0x10 -> 32'h0000_0001; lb @0x12 -> 32'hFFFF_FF81; lbu @0x13 -> 32'h0000_0080; lhu @0x12 -> 32'h0000_8081.
REQ-044 The bench SHALL cover: sh 32'hAAAA_1234 @0x22 over stored word 32'hFFFF_FFFF at 0x20, then lw @0x20 -> 32'h1234_FFFF.
REQ-045 The bench SHALL cover: sw @0x06, or lw @0x400 with DEPTH_WORDS=256 -> RAM unchanged, readdata 0, err=1 next cycle and still 1 after 10 idle cycles.
REQ-046 The bench SHALL cover: COMPARE=5 and CTRL=3'b111 -> match and irq set on the edge after COUNT==5, then COUNT=0 and wraps repeatedly; sw 1 to STATUS -> irq=0 next cycle.
REQ-047 The bench SHALL cover: sw COUNT=100 while counting enabled -> COUNT reads 100 next cycle, not old+1; rst mid-count -> all timer reads 0, irq=0.
REQ-048 The bench SHALL cover: build without DM_TIMER_EN, then lw @MMIO_BASE -> readdata 0, err=1, irq=0.
